// File: rtl/mc_control_if.sv
// ALU operation select type and the control-unit bus bundle.
// The master side is the control unit: it reads instruction fields and
// datapath/memory status and drives every datapath/memory control line.
// The slave side is the datapath, instruction register and memory port.

package typedefs_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } aluop_sel_t;
endpackage

interface mc_control_if;
  import typedefs_pkg::*;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;

  logic       mem_req;
  logic       mem_we;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [2:0] imm_src;
  aluop_sel_t alu_sel;
  logic       retire;
  logic       illegal;

  modport master (
    input  opcode, funct3, funct7b5, zero, mem_ready,
    output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, imm_src, alu_sel,
           retire, illegal
  );

  modport slave (
    output opcode, funct3, funct7b5, zero, mem_ready,
    input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, imm_src, alu_sel,
           retire, illegal
  );
endinterface

// File: rtl/mc_control.sv
// Multicycle control unit for the simplified RV32I core.
// Walks each instruction through fetch, decode, execute, memory and
// writeback states. The state register is the only storage; every control
// output is decoded combinationally from the state and the current inputs,
// so memory wait cycles simply hold the state and its outputs.

module mc_control
  import typedefs_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  mc_control_if.master  bus
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RALU   = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_LUI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_t;

  state_t state;
  state_t next_state;

  // funct3/funct7b5 to ALU operation; SUB only exists for register-register ops
  function automatic aluop_sel_t funct_alu(input logic [2:0] f3,
                                           input logic       f7b5,
                                           input logic       is_rtype);
    aluop_sel_t op;
    case (f3)
      3'b000:  op = (is_rtype && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // State register; reset aborts any instruction straight back to fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control decode; memory states hold until mem_ready
  always_comb begin
    next_state     = state;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.adr_src    = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.result_src = 2'b00;
    bus.imm_src    = IMM_I;
    bus.alu_sel    = ALU_ADD;
    bus.retire     = 1'b0;
    bus.illegal    = 1'b0;

    case (state)
      S_FETCH: begin
        bus.mem_req    = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          next_state   = S_DECODE;
        end
      end

      S_DECODE: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        bus.imm_src   = IMM_B;
        case (bus.opcode)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RALU:           next_state = S_EXECUTER;
          OP_IALU:           next_state = S_EXECUTEI;
          OP_BRANCH:         next_state = (bus.funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          OP_JAL:            next_state = S_JAL;
          OP_LUI:            next_state = S_LUI;
          default:           next_state = S_TRAP;
        endcase
      end

      S_MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        if (bus.opcode == OP_STORE) begin
          bus.imm_src = IMM_S;
          next_state  = S_MEMWRITE;
        end else begin
          bus.imm_src = IMM_I;
          next_state  = S_MEMREAD;
        end
      end

      S_MEMREAD: begin
        bus.mem_req = 1'b1;
        bus.adr_src = 1'b1;
        if (bus.mem_ready) begin
          next_state = S_MEMWB;
        end
      end

      S_MEMWB: begin
        bus.result_src = 2'b01;
        bus.reg_write  = 1'b1;
        bus.retire     = 1'b1;
        next_state     = S_FETCH;
      end

      S_MEMWRITE: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        bus.adr_src = 1'b1;
        if (bus.mem_ready) begin
          bus.retire = 1'b1;
          next_state = S_FETCH;
        end
      end

      S_EXECUTER: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b00;
        bus.alu_sel   = funct_alu(bus.funct3, bus.funct7b5, 1'b1);
        next_state    = S_ALUWB;
      end

      S_EXECUTEI: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.imm_src   = IMM_I;
        bus.alu_sel   = funct_alu(bus.funct3, bus.funct7b5, 1'b0);
        next_state    = S_ALUWB;
      end

      S_LUI: begin
        bus.alu_src_a = 2'b11;
        bus.alu_src_b = 2'b01;
        bus.imm_src   = IMM_U;
        next_state    = S_ALUWB;
      end

      S_ALUWB: begin
        bus.reg_write = 1'b1;
        bus.retire    = 1'b1;
        next_state    = S_FETCH;
      end

      S_BRANCH: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b00;
        bus.alu_sel   = ALU_SUB;
        bus.retire    = 1'b1;
        bus.pc_write  = bus.funct3[0] ? !bus.zero : bus.zero;
        next_state    = S_FETCH;
      end

      S_JAL: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        bus.pc_write  = 1'b1;
        next_state    = S_ALUWB;
      end

      S_TRAP: begin
        bus.illegal = 1'b1;
      end

      default: begin
        next_state = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: random instruction streams with random memory wait
// cycles, checked cycle by cycle against a transaction-level model that
// expands each instruction into its expected sequence of control vectors.

module tb_mc_control;
  import typedefs_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  // Free-running core clock
  always #5 clk = ~clk;

  mc_control_if bus();

  mc_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        mr;
    logic        z;
    logic [31:0] exp;
  } step_t;

  step_t plan[$];
  int checks = 0;
  int fails  = 0;
  int passed;

  function automatic logic [31:0] pack(input logic mreq, input logic mwe, input logic adr,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic ret, input logic ill,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] rs, input logic [2:0] imm,
                                       input logic [3:0] alu);
    return {11'd0, mreq, mwe, adr, irw, pcw, rw, ret, ill, a, b, rs, imm, alu};
  endfunction

  function automatic logic [31:0] observed();
    return pack(bus.mem_req, bus.mem_we, bus.adr_src, bus.ir_write, bus.pc_write,
                bus.reg_write, bus.retire, bus.illegal, bus.alu_src_a, bus.alu_src_b,
                bus.result_src, bus.imm_src, bus.alu_sel);
  endfunction

  function automatic logic [31:0] fetchVec(input logic done);
    return pack(1'b1, 1'b0, 1'b0, done, done, 1'b0, 1'b0, 1'b0,
                2'b00, 2'b10, 2'b10, 3'b000, ALU_ADD);
  endfunction

  function automatic logic isLegal(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
      7'b1101111, 7'b0110111: return 1'b1;
      7'b1100011:             return (f3 == 3'b000) || (f3 == 3'b001);
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] aluFor(input logic [2:0] f3, input logic f7b5, input logic rtype);
    case (f3)
      3'd0:    return (rtype && f7b5) ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return f7b5 ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  task automatic addStep(input logic mr, input logic z, input logic [31:0] e);
    step_t s;
    s.mr = mr;
    s.z = z;
    s.exp = e;
    plan.push_back(s);
  endtask

  function automatic logic rnd();
    return 1'($urandom % 2);
  endfunction

  // Expand one instruction into its expected per-cycle control vectors
  task automatic buildInstr(input logic [6:0] op, input logic [2:0] f3, input logic f7b5,
                            input int fw, input int mw, input logic zb, output logic trapped);
    logic [31:0] wb;
    wb = pack(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, ALU_ADD);
    trapped = 1'b0;
    for (int i = 0; i < fw; i++) addStep(1'b0, rnd(), fetchVec(1'b0));
    addStep(1'b1, rnd(), fetchVec(1'b1));
    addStep(rnd(), rnd(), pack(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b010, ALU_ADD));
    if (!isLegal(op, f3)) begin
      trapped = 1'b1;
      for (int i = 0; i < 10; i++)
        addStep(rnd(), rnd(), pack(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, ALU_ADD));
    end else begin
      case (op)
        7'b0000011: begin
          addStep(rnd(), rnd(), pack(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, ALU_ADD));
          for (int i = 0; i < mw; i++)
            addStep(1'b0, rnd(), pack(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, ALU_ADD));
          addStep(1'b1, rnd(), pack(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, ALU_ADD));
          addStep(rnd(), rnd(), pack(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b01, 3'b000, ALU_ADD));
        end
        7'b0100011: begin
          addStep(rnd(), rnd(), pack(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b001, ALU_ADD));
          for (int i = 0; i < mw; i++)
            addStep(1'b0, rnd(), pack(1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, ALU_ADD));
          addStep(1'b1, rnd(), pack(1, 1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, ALU_ADD));
        end
        7'b0110011: begin
          addStep(rnd(), rnd(), pack(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b000,
                                     aluFor(f3, f7b5, 1'b1)));
          addStep(rnd(), rnd(), wb);
        end
        7'b0010011: begin
          addStep(rnd(), rnd(), pack(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000,
                                     aluFor(f3, f7b5, 1'b0)));
          addStep(rnd(), rnd(), wb);
        end
        7'b0110111: begin
          addStep(rnd(), rnd(), pack(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b01, 2'b00, 3'b100, ALU_ADD));
          addStep(rnd(), rnd(), wb);
        end
        7'b1101111: begin
          addStep(rnd(), rnd(), pack(0, 0, 0, 0, 1, 0, 0, 0, 2'b01, 2'b10, 2'b00, 3'b000, ALU_ADD));
          addStep(rnd(), rnd(), wb);
        end
        default: begin
          addStep(rnd(), zb, pack(0, 0, 0, 0, (f3 == 3'b000) ? zb : !zb, 0, 1, 0,
                                  2'b10, 2'b00, 2'b00, 3'b000, ALU_SUB));
        end
      endcase
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Play the planned steps one cycle each, sampling on the falling edge
  task automatic applyStimulus(input string tag, input logic [6:0] op,
                               input logic [2:0] f3, input logic f7b5);
    step_t s;
    int cyc = 0;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      @(posedge clk);
      #1;
      if (cyc == 0) begin
        bus.opcode = op;
        bus.funct3 = f3;
        bus.funct7b5 = f7b5;
      end
      bus.mem_ready = s.mr;
      bus.zero = s.z;
      @(negedge clk);
      checkOutput($sformatf("%s c%0d", tag, cyc), observed(), s.exp);
      cyc++;
    end
  endtask

  task automatic resetPulse(input string tag);
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput(tag, observed(), fetchVec(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic runInstr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic f7b5, input int fw, input int mw, input logic zb);
    logic trapped;
    buildInstr(op, f3, f7b5, fw, mw, zb, trapped);
    applyStimulus(tag, op, f3, f7b5);
    if (trapped) resetPulse({tag, " rst"});
  endtask

  logic [6:0] ops[7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                         7'b1100011, 7'b1101111, 7'b0110111};

  // Directed cases first, then a random instruction stream
  initial begin
    logic [6:0] op;
    logic [2:0] f3;

    rst_n = 1'b0;
    bus.opcode = 7'd0;
    bus.funct3 = 3'd0;
    bus.funct7b5 = 1'b0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    #2;
    checkOutput("reset idle", observed(), fetchVec(1'b0));
    bus.mem_ready = 1'b1;
    #1;
    checkOutput("reset ready", observed(), fetchVec(1'b1));
    bus.mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    runInstr("sub",  7'b0110011, 3'b000, 1'b1, 0, 0, 1'b0);
    runInstr("lw2w", 7'b0000011, 3'b010, 1'b0, 0, 2, 1'b0);
    runInstr("beqz", 7'b1100011, 3'b000, 1'b0, 0, 0, 1'b1);
    runInstr("bnez", 7'b1100011, 3'b001, 1'b0, 0, 0, 1'b1);
    runInstr("srai", 7'b0010011, 3'b101, 1'b1, 0, 0, 1'b0);
    runInstr("addi", 7'b0010011, 3'b000, 1'b1, 0, 0, 1'b0);
    runInstr("ill0", 7'b0000000, 3'b000, 1'b0, 0, 0, 1'b0);
    runInstr("blt",  7'b1100011, 3'b100, 1'b0, 1, 0, 1'b0);

    // Store stalled in its write cycle, then reset mid-request
    addStep(1'b1, 1'b0, fetchVec(1'b1));
    addStep(1'b0, 1'b0, pack(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b010, ALU_ADD));
    addStep(1'b0, 1'b0, pack(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b001, ALU_ADD));
    addStep(1'b0, 1'b0, pack(1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, ALU_ADD));
    applyStimulus("swabort", 7'b0100011, 3'b010, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("swabort rst", observed(), fetchVec(1'b0));
    @(posedge clk);
    #1;
    checkOutput("swabort held", observed(), fetchVec(1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 60; n++) begin
      if ($urandom % 8 == 0) begin
        op = 7'($urandom);
      end else begin
        op = ops[$urandom % 7];
      end
      f3 = 3'($urandom);
      if (op == 7'b1100011 && ($urandom % 4) != 0) f3 = 3'($urandom % 2);
      runInstr($sformatf("rnd%0d op%b f%0d", n, op, f3), op, f3, rnd(),
               $urandom % 3, $urandom % 3, rnd());
    end

    passed = checks - fails;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
